// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, reset PC, fetch-entry layout and FIFO depth for the fetch stage.
package fetch_pkg;
  localparam int FETCH_ADDR_W = 9;
  localparam int FETCH_DATA_W = 16;
  localparam int FETCH_RESET_PC = 0;
  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry synchronous FIFO of fetch entries with push/pop/flush; head is registered.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int W = $bits(fetch_entry_t)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [W-1:0]     d,
  output logic [W-1:0]     q,
  output logic [CNT_W-1:0] count
);
  logic [W-1:0] e1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q     <= '0;
      e1    <= '0;
      count <= '0;
    end else begin
      count <= flush ? '0 : count + CNT_W'(push) - CNT_W'(pop);
      if (push && (count == 0 || (count == 1 && pop))) q <= d;
      else if (pop) q <= e1;
      if (push && (count == 2 || (count == 1 && !pop))) e1 <= d;
    end
  end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage with 1-cycle memory latency absorption, credit-based issue and jump squash.
// Optional FETCH_COUNT_EN adds fetch_count, the number of completed output handshakes.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int ADDR_W = FETCH_ADDR_W,
  parameter int DATA_W = FETCH_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc
`ifdef FETCH_COUNT_EN
  ,
  output logic [15:0]       fetch_count
`endif
);
  logic [ADDR_W-1:0] issue_pc, req_pc;
  logic inflight, squash, pop, push, issue_en;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0] credit;
  logic [ADDR_W+DATA_W-1:0] head;
  assign mem_addr  = issue_pc;
  assign out_valid = count != 0;
  assign pop       = out_valid && out_ready;
  // Occupancy after this cycle's pop, counting the word still in the memory pipeline.
  assign credit    = {1'b0, count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
  assign issue_en  = !jump_en && credit < (CNT_W+1)'(FIFO_DEPTH);
  assign push      = inflight && !squash;
  assign {out_pc, out_instr} = head;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      inflight <= 1'b0;
      squash   <= 1'b0;
    end else begin
      squash   <= jump_en;
      inflight <= issue_en;
      if (jump_en) issue_pc <= jump_addr;
      else if (issue_en) begin
        req_pc   <= issue_pc;
        issue_pc <= issue_pc + 1'b1;
      end
    end
  end
  fetch_fifo #(.W(ADDR_W + DATA_W)) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .pop  (pop),
    .flush(jump_en),
    .d    ({req_pc, mem_data}),
    .q    (head),
    .count(count)
  );
`ifdef FETCH_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fetch_count <= '0;
    else if (pop) fetch_count <= fetch_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed self-checking bench for instr_fetch with a 1-cycle synchronous code memory model.
module tb_instr_fetch;
  logic        clk, rst_n, jump_en, out_ready, out_valid;
  logic [8:0]  mem_addr, jump_addr, out_pc;
  logic [15:0] mem_data, out_instr;
  int pass = 0, total = 0;
`ifdef FETCH_COUNT_EN
  logic [15:0] fetch_count;
`endif

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_data(mem_data),
    .jump_en(jump_en), .jump_addr(jump_addr), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
`ifdef FETCH_COUNT_EN
    , .fetch_count(fetch_count)
`endif
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [15:0] img(input logic [8:0] a);
    return {7'h5A, a};
  endfunction

  always @(posedge clk) mem_data <= img(mem_addr);

  task automatic do_reset(input logic rdy);
    @(negedge clk);
    rst_n = 0; jump_en = 0; jump_addr = 0; out_ready = rdy;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst_n = 0; jump_en = 0; jump_addr = 0; out_ready = 1;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %0h want 0", out_valid); else pass++;
    total++; if (out_pc !== 9'h0) $display("FAIL reset_pc got %0h want 0", out_pc); else pass++;
    total++; if (out_instr !== 16'h0) $display("FAIL reset_instr got %0h want 0", out_instr); else pass++;
    total++; if (mem_addr !== 9'h0) $display("FAIL reset_addr got %0h want 0", mem_addr); else pass++;
`ifdef FETCH_COUNT_EN
    total++; if (fetch_count !== 16'h0) $display("FAIL reset_count got %0h want 0", fetch_count); else pass++;
`endif
    rst_n = 1;
  endtask

  task automatic test_stream;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) $display("FAIL stream_edge1_valid got %0h want 0", out_valid); else pass++;
    total++; if (mem_addr !== 9'h1) $display("FAIL stream_edge1_addr got %0h want 1", mem_addr); else pass++;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b1 || out_pc !== 9'(i))
        $display("FAIL stream_pc got v=%0h pc=%0h want v=1 pc=%0h", out_valid, out_pc, i); else pass++;
      total++; if (out_instr !== img(9'(i)))
        $display("FAIL stream_instr got %0h want %0h", out_instr, img(9'(i))); else pass++;
    end
  endtask

  task automatic test_stall;
    do_reset(0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b1 || out_pc !== 9'h0)
        $display("FAIL stall_head got v=%0h pc=%0h want v=1 pc=0", out_valid, out_pc); else pass++;
      total++; if (mem_addr !== 9'h2) $display("FAIL stall_addr got %0h want 2", mem_addr); else pass++;
    end
    out_ready = 1;
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b1 || out_pc !== 9'(i))
        $display("FAIL stall_release got v=%0h pc=%0h want v=1 pc=%0h", out_valid, out_pc, i); else pass++;
    end
  endtask

  task automatic test_jump;
    do_reset(1);
    repeat (5) @(negedge clk);
    total++; if (out_pc !== 9'h3) $display("FAIL jump_pre got %0h want 3", out_pc); else pass++;
    jump_en = 1; jump_addr = 9'h100;
    @(negedge clk);
    jump_en = 0;
    total++; if (out_valid !== 1'b0) $display("FAIL jump_n1_valid got %0h want 0", out_valid); else pass++;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) $display("FAIL jump_n2_valid got %0h want 0", out_valid); else pass++;
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_pc !== 9'h100)
      $display("FAIL jump_target got v=%0h pc=%0h want v=1 pc=100", out_valid, out_pc); else pass++;
    total++; if (out_instr !== img(9'h100)) $display("FAIL jump_instr got %0h want %0h", out_instr, img(9'h100)); else pass++;
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_pc !== 9'h101)
      $display("FAIL jump_next got v=%0h pc=%0h want v=1 pc=101", out_valid, out_pc); else pass++;
  endtask

  task automatic test_jump_handshake;
    do_reset(1);
    repeat (7) @(negedge clk);
    total++; if (out_pc !== 9'h5 || mem_addr !== 9'h7)
      $display("FAIL jhs_pre got pc=%0h addr=%0h want pc=5 addr=7", out_pc, mem_addr); else pass++;
    jump_en = 1; jump_addr = 9'h7;
    @(negedge clk);
    jump_en = 0;
    total++; if (out_valid !== 1'b0) $display("FAIL jhs_n1_valid got %0h want 0", out_valid); else pass++;
`ifdef FETCH_COUNT_EN
    total++; if (fetch_count !== 16'd6) $display("FAIL jhs_count got %0d want 6", fetch_count); else pass++;
`endif
    @(negedge clk);
    total++; if (out_valid !== 1'b0) $display("FAIL jhs_n2_valid got %0h want 0", out_valid); else pass++;
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_pc !== 9'h7)
      $display("FAIL jhs_target got v=%0h pc=%0h want v=1 pc=7", out_valid, out_pc); else pass++;
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_pc !== 9'h8)
      $display("FAIL jhs_next got v=%0h pc=%0h want v=1 pc=8", out_valid, out_pc); else pass++;
  endtask

  task automatic test_wrap;
    logic [8:0] e;
    do_reset(1);
    repeat (3) @(negedge clk);
    jump_en = 1; jump_addr = 9'h1FE;
    @(negedge clk);
    jump_en = 0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      e = 9'h1FE + 9'(i);
      @(negedge clk);
      total++; if (out_valid !== 1'b1 || out_pc !== e || out_instr !== img(e))
        $display("FAIL wrap got v=%0h pc=%0h instr=%0h want v=1 pc=%0h instr=%0h", out_valid, out_pc, out_instr, e, img(e)); else pass++;
    end
  endtask

  task automatic test_back_to_back;
    do_reset(1);
    repeat (4) @(negedge clk);
    jump_en = 1; jump_addr = 9'h050;
    @(negedge clk);
    jump_addr = 9'h0C0;
    total++; if (out_valid !== 1'b0) $display("FAIL b2b_n1_valid got %0h want 0", out_valid); else pass++;
    @(negedge clk);
    jump_en = 0;
    total++; if (out_valid !== 1'b0) $display("FAIL b2b_n2_valid got %0h want 0", out_valid); else pass++;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) $display("FAIL b2b_n3_valid got %0h want 0", out_valid); else pass++;
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_pc !== 9'h0C0)
      $display("FAIL b2b_target got v=%0h pc=%0h want v=1 pc=c0", out_valid, out_pc); else pass++;
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_pc !== 9'h0C1)
      $display("FAIL b2b_next got v=%0h pc=%0h want v=1 pc=c1", out_valid, out_pc); else pass++;
  endtask

  task automatic test_midreset;
    do_reset(1);
    repeat (4) @(negedge clk);
    out_ready = 0;
    repeat (3) @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_pc !== 9'h2)
      $display("FAIL mid_full got v=%0h pc=%0h want v=1 pc=2", out_valid, out_pc); else pass++;
`ifdef FETCH_COUNT_EN
    total++; if (fetch_count !== 16'd2) $display("FAIL mid_count_pre got %0d want 2", fetch_count); else pass++;
`endif
    rst_n = 0;
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL mid_async_valid got %0h want 0", out_valid); else pass++;
    total++; if (mem_addr !== 9'h0) $display("FAIL mid_async_addr got %0h want 0", mem_addr); else pass++;
`ifdef FETCH_COUNT_EN
    total++; if (fetch_count !== 16'd0) $display("FAIL mid_count_rst got %0d want 0", fetch_count); else pass++;
`endif
    @(negedge clk);
    rst_n = 1; out_ready = 1;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) $display("FAIL mid_edge1_valid got %0h want 0", out_valid); else pass++;
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_pc !== 9'h0)
      $display("FAIL mid_restart got v=%0h pc=%0h want v=1 pc=0", out_valid, out_pc); else pass++;
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_pc !== 9'h1)
      $display("FAIL mid_next got v=%0h pc=%0h want v=1 pc=1", out_valid, out_pc); else pass++;
`ifdef FETCH_COUNT_EN
    total++; if (fetch_count !== 16'd1) $display("FAIL mid_count_post got %0d want 1", fetch_count); else pass++;
`endif
  endtask

  initial begin
    rst_n = 0; jump_en = 0; jump_addr = 0; out_ready = 1;
    test_reset;
    test_stream;
    test_stall;
    test_jump;
    test_jump_handshake;
    test_wrap;
    test_back_to_back;
    test_midreset;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
